// File: rtl/i2s_rx_pkg.sv
// Shared types and constants for the multi-lane I2S / left-justified receiver.
package i2s_rx_pkg;

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_LEFT  = 2'd1,
    S_RIGHT = 2'd2
  } rx_state_e;

  localparam int I2S_DATA_W = 24;
  localparam int I2S_SLOT_W = 32;

  // Bit counter must hold 0..SLOT_W (saturating value included).
  function automatic int cnt_w(input int slot_w);
    return $clog2(slot_w + 1);
  endfunction

endpackage

// File: rtl/i2s_rx_multilane_shifter.sv
// One serial lane: MSB-first shift register with enable and synchronous clear.
module i2s_lane_shifter #(
  parameter int DATA_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              sd_i,
  output logic [DATA_W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= '0;
    end else if (clr_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= {q_o[DATA_W-2:0], sd_i};
    end
  end

endmodule

// File: rtl/i2s_rx_multilane.sv
// Multi-lane I2S / left-justified receiver: NUM_LANES stereo SD lines sharing
// one SCK/WS pair, full frames delivered on valid/ready with error flags.
module i2s_rx_multilane
  import i2s_rx_pkg::*;
#(
  parameter int NUM_LANES  = 2,
  parameter int DATA_W     = I2S_DATA_W,
  parameter int SLOT_W     = I2S_SLOT_W,
  parameter int DELAY_BITS = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          sck_i,
  input  logic                          ws_i,
  input  logic [NUM_LANES-1:0]          sd_i,
  output logic [2*NUM_LANES*DATA_W-1:0] frame_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          overrun_o,
  output logic                          frame_err_o,
  input  logic                          clear_i
);

  localparam int CNT_W    = cnt_w(SLOT_W);
  localparam int LAST_BIT = DELAY_BITS + DATA_W - 1;
  localparam int FRAME_W  = 2 * NUM_LANES * DATA_W;
  localparam logic [CNT_W-1:0] SLOT_K      = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] SLOT_LAST_K = CNT_W'(SLOT_W - 1);

  if (DELAY_BITS + DATA_W > SLOT_W) begin : g_bad_slot
    $error("i2s_rx_multilane: DELAY_BITS + DATA_W exceeds SLOT_W");
  end
  if (NUM_LANES < 1) begin : g_bad_lanes
    $error("i2s_rx_multilane: NUM_LANES must be at least 1");
  end

  rx_state_e          state_q, state_d;
  logic               sck_q, ws_q;
  logic [CNT_W-1:0]   k_q, k_cur;
  logic               sck_rise, ws_chg, in_win, shift_en, shift_clr, last_bit;
  logic               slot_done_q, slot_err, lft_done, frm_done;
  logic               lft_p0, vld_p0;
  logic [DATA_W-1:0]  shift_q [NUM_LANES];
  logic [DATA_W-1:0]  left_q  [NUM_LANES];
  logic [FRAME_W-1:0] frame_d;

  // Stage p0: SCK edge detect, bit index, slot checks and FSM decisions
  always_comb begin
    sck_rise  = sck_i & ~sck_q;
    ws_chg    = sck_rise & (ws_i != ws_q);
    k_cur     = k_q;
    state_d   = state_q;
    slot_err  = 1'b0;
    in_win    = 1'b0;
    shift_en  = 1'b0;
    last_bit  = 1'b0;
    lft_done  = 1'b0;
    frm_done  = 1'b0;
    if (sck_rise) begin
      if (ws_chg)              k_cur = '0;
      else if (k_q != SLOT_K)  k_cur = k_q + CNT_W'(1);
    end
    if (ws_chg && state_q != S_SYNC) begin
      slot_err = (k_q != SLOT_LAST_K) | ~slot_done_q |
                 ((state_q == S_LEFT) & ~ws_i) | ((state_q == S_RIGHT) & ws_i);
    end
    if (ws_chg) begin
      if (slot_err) begin
        state_d = S_SYNC;
      end else begin
        unique case (state_q)
          S_SYNC:  if (!ws_i) state_d = S_LEFT;
          S_LEFT:  state_d = S_RIGHT;
          S_RIGHT: state_d = S_LEFT;
          default: state_d = S_SYNC;
        endcase
      end
    end
    // DELAY_BITS = 0 puts the MSB on the WS edge itself, so gate on the next state.
    in_win    = (int'(k_cur) >= DELAY_BITS) && (int'(k_cur) <= LAST_BIT);
    shift_en  = sck_rise & in_win & (state_d != S_SYNC);
    shift_clr = (state_d == S_SYNC);
    last_bit  = shift_en & (int'(k_cur) == LAST_BIT);
    lft_done  = last_bit & (state_d == S_LEFT);
    frm_done  = last_bit & (state_d == S_RIGHT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_SYNC;
      sck_q       <= 1'b0;
      ws_q        <= 1'b0;
      k_q         <= '0;
      slot_done_q <= 1'b0;
      lft_p0      <= 1'b0;
      vld_p0      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_q       <= sck_i;
      lft_p0      <= lft_done;
      vld_p0      <= frm_done;
      frame_err_o <= slot_err;
      if (sck_rise) begin
        ws_q <= ws_i;
        k_q  <= k_cur;
      end
      if (ws_chg)        slot_done_q <= last_bit;
      else if (last_bit) slot_done_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    i2s_lane_shifter #(.DATA_W(DATA_W)) u_shift (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (shift_clr),
      .en_i   (shift_en),
      .sd_i   (sd_i[g]),
      .q_o    (shift_q[g])
    );
  end

  // Stage p1: shifters now hold the complete word; stage left, assemble frame
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int l = 0; l < NUM_LANES; l++) left_q[l] <= '0;
    end else if (slot_err) begin
      for (int l = 0; l < NUM_LANES; l++) left_q[l] <= '0;
    end else if (lft_p0) begin
      for (int l = 0; l < NUM_LANES; l++) left_q[l] <= shift_q[l];
    end
  end

  always_comb begin
    frame_d = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      frame_d[(2*l)*DATA_W   +: DATA_W] = left_q[l];
      frame_d[(2*l+1)*DATA_W +: DATA_W] = shift_q[l];
    end
  end

  // Stage p2: output register with valid/ready handshake and overrun detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_o   <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (vld_p0 && (!valid_o || ready_i)) begin
        frame_o <= frame_d;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (vld_p0 && valid_o && !ready_i) overrun_o <= 1'b1;
      else if (clear_i)                  overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx_multilane.sv
// Scoreboard bench for i2s_rx_multilane: an I2S instance plus a left-justified
// instance that only sees SCK during the data-delay section.
module tb_i2s_rx_multilane;

  localparam int NL = 2;
  localparam int DW = 24;
  localparam int FW = 2 * NL * DW;

  logic          clk = 1'b0;
  logic          rst_n, sck, ws, ready, clear, lj_en, sck_lj;
  logic [NL-1:0] sd;
  logic [FW-1:0] frame, frame_lj;
  logic          valid, valid_lj, overrun, overrun_lj, ferr, ferr_lj;

  always #5 clk = ~clk;
  assign sck_lj = sck & lj_en;

  i2s_rx_multilane #(.NUM_LANES(NL), .DATA_W(DW), .SLOT_W(32), .DELAY_BITS(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sck_i(sck), .ws_i(ws), .sd_i(sd),
    .frame_o(frame), .valid_o(valid), .ready_i(ready),
    .overrun_o(overrun), .frame_err_o(ferr), .clear_i(clear));

  i2s_rx_multilane #(.NUM_LANES(NL), .DATA_W(DW), .SLOT_W(32), .DELAY_BITS(0)) dut_lj (
    .clk_i(clk), .rst_ni(rst_n), .sck_i(sck_lj), .ws_i(ws), .sd_i(sd),
    .frame_o(frame_lj), .valid_o(valid_lj), .ready_i(1'b1),
    .overrun_o(overrun_lj), .frame_err_o(ferr_lj), .clear_i(1'b0));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_rbit_cyc = 0;
  int vld_rise_cyc = 0;
  int vld_hi_cnt = 0;
  int err_cnt = 0;
  logic valid_prev = 1'b0;
  logic [FW-1:0] q[$];
  logic [FW-1:0] q_lj[$];

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [DW-1:0] l0, l1, r0, r1);
    return {r1, l1, r0, l0};
  endfunction

  // Word seen by a receiver with delay rx_dly when the stream was sent with delay tx_dly.
  function automatic logic [DW-1:0] xf(input logic [DW-1:0] w, input int tx_dly, input int rx_dly);
    if (tx_dly == rx_dly) return w;
    if (tx_dly == 0)      return {w[DW-2:0], 1'b0};
    return {1'b0, w[DW-1:1]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && !valid_prev) vld_rise_cyc = cyc;
      if (valid) vld_hi_cnt++;
      if (ferr) err_cnt++;
      if (valid && ready) begin
        if (q.size() == 0) check("unexpected_frame", FW'(valid), FW'(0));
        else               check("frame", frame, q.pop_front());
      end
      if (valid_lj) begin
        if (q_lj.size() == 0) check("unexpected_lj", FW'(valid_lj), FW'(0));
        else                  check("frame_lj", frame_lj, q_lj.pop_front());
      end
    end
    valid_prev = valid;
  end

  task automatic send_slot(input logic w, input logic [DW-1:0] w0, w1,
                           input int dly, input int len, input int kfrom);
    for (int k = kfrom; k < len; k++) begin
      @(negedge clk);
      sck = 1'b0;
      ws  = w;
      if (k >= dly && k < dly + DW) begin
        sd[0] = w0[DW-1-(k-dly)];
        sd[1] = w1[DW-1-(k-dly)];
      end else begin
        sd = '0;
      end
      @(negedge clk);
      @(negedge clk);
      sck = 1'b1;
      if (w && k == dly + DW - 1) last_rbit_cyc = cyc;
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input int dly, input logic [DW-1:0] l0, l1, r0, r1,
                           input bit exp_dut, input bit exp_lj);
    if (exp_dut) q.push_back(mk(xf(l0, dly, 1), xf(l1, dly, 1), xf(r0, dly, 1), xf(r1, dly, 1)));
    if (exp_lj)  q_lj.push_back(mk(xf(l0, dly, 0), xf(l1, dly, 0), xf(r0, dly, 0), xf(r1, dly, 0)));
    send_slot(1'b0, l0, l1, dly, 32, 0);
    send_slot(1'b1, r0, r1, dly, 32, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] a, b, c, d;
    logic [FW-1:0] held;
    int e0;
    rst_n = 1'b0; sck = 1'b0; ws = 1'b0; sd = '0;
    ready = 1'b1; clear = 1'b0; lj_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_frame",   frame,       FW'(0));
    check("rst_valid",   FW'(valid),  FW'(0));
    check("rst_overrun", FW'(overrun), FW'(0));
    check("rst_ferr",    FW'(ferr),   FW'(0));
    rst_n = 1'b1;

    // Stream begins inside a right slot: nothing may be delivered for it.
    send_slot(1'b1, 24'h111111, 24'h222222, 1, 32, 0);
    check("no_partial", FW'(vld_hi_cnt), FW'(0));

    vld_hi_cnt = 0;
    run_frame(1, 24'h123456, 24'h800000, 24'hABCDEF, 24'h7FFFFF, 1'b1, 1'b0);
    check("latency", FW'(vld_rise_cyc - last_rbit_cyc), FW'(2));
    check("valid_pulses", FW'(vld_hi_cnt), FW'(1));
    for (int i = 0; i < 2; i++) begin
      a = DW'($urandom()); b = DW'($urandom()); c = DW'($urandom()); d = DW'($urandom());
      run_frame(1, a, b, c, d, 1'b1, 1'b0);
    end

    // Data-delay section: second instance joins with DELAY_BITS = 0.
    @(negedge clk);
    sck = 1'b0;
    lj_en = 1'b1;
    run_frame(1, 24'h0F0F0F, 24'hF0F0F0, 24'h5A5A5A, 24'hA5A5A5, 1'b1, 1'b0);
    run_frame(1, 24'h123456, 24'h800000, 24'hABCDEF, 24'h7FFFFF, 1'b1, 1'b1);
    run_frame(0, 24'h123456, 24'h800000, 24'hABCDEF, 24'h7FFFFF, 1'b1, 1'b1);
    a = DW'($urandom()); b = DW'($urandom()); c = DW'($urandom()); d = DW'($urandom());
    run_frame(0, a, b, c, d, 1'b1, 1'b1);
    lj_en = 1'b0;
    check("lj_drained", FW'(q_lj.size()), FW'(0));

    // Back-pressure: three frames with ready low, only the first is kept.
    ready = 1'b0;
    held = mk(24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C);
    run_frame(1, 24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C, 1'b1, 1'b0);
    check("ovr_first_valid", FW'(valid), FW'(1));
    check("ovr_first_flag",  FW'(overrun), FW'(0));
    run_frame(1, 24'h111111, 24'h222222, 24'h333333, 24'h444444, 1'b0, 1'b0);
    run_frame(1, 24'h555555, 24'h666666, 24'h777777, 24'h888888, 1'b0, 1'b0);
    check("held_frame", frame, held);
    check("held_valid", FW'(valid), FW'(1));
    check("overrun_set", FW'(overrun), FW'(1));
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    check("overrun_clr", FW'(overrun), FW'(0));
    @(posedge clk); #1 ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("valid_drop", FW'(valid), FW'(0));

    // Short left slot: one error pulse, that frame lost, next frame intact.
    e0 = err_cnt;
    send_slot(1'b0, 24'hDEAD00, 24'hBEEF00, 1, 30, 0);
    send_slot(1'b1, 24'hCAFE00, 24'hF00D00, 1, 32, 0);
    run_frame(1, 24'h13579B, 24'h2468AC, 24'hFEDCBA, 24'h987654, 1'b1, 1'b0);
    check("ferr_pulses", FW'(err_cnt - e0), FW'(1));

    // Reset in the middle of a right slot, then resume mid-stream.
    send_slot(1'b0, 24'h314159, 24'h271828, 1, 32, 0);
    send_slot(1'b1, 24'h161803, 24'h141421, 1, 12, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_frame", frame, FW'(0));
    check("midrst_valid", FW'(valid), FW'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_slot(1'b1, 24'h161803, 24'h141421, 1, 32, 12);
    e0 = err_cnt;
    run_frame(1, 24'h765432, 24'h89ABCD, 24'h000001, 24'hFFFFFE, 1'b1, 1'b0);
    check("post_rst_ferr", FW'(err_cnt - e0), FW'(0));

    repeat (10) @(negedge clk);
    check("q_empty", FW'(q.size()), FW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_rx_multilane.md
Name: i2s_rx_multilane

Overview:
Parametrised I²S/left-justified receiver capturing NUM_LANES serial data lines that share one SCK/WS pair (2 channels per lane, e.g. a MEMS microphone array). Samples are DATA_W-bit, MSB-first, in SLOT_W-bit slots, with a configurable data delay. A complete frame (all lanes, L+R) is presented on a valid/ready interface to the downstream DSP. Slot-length framing errors and downstream overruns are detected and flagged.

Parameters:
NUM_LANES, 2, number of SD inputs; output carries 2*NUM_LANES samples
DATA_W, 24, sample width in bits (signed two's complement)
SLOT_W, 32, SCK periods per channel slot
DELAY_BITS, 1, SCK rises between WS transition and MSB (1 = I²S, 0 = left-justified)

Ports:
clk_i  in  1  system clock; all logic on rising edge
rst_ni  in  1  asynchronous active-low reset
sck_i  in  1  serial clock, synchronous to clk_i, period >= 4 clk_i
ws_i  in  1  word select, 0 = left, 1 = right
sd_i  in  NUM_LANES  serial data, bit l = lane l, valid on SCK rise
frame_o  out  2*NUM_LANES*DATA_W  sample (2*l+c), c = 0 left / 1 right, at bits [(2*l+c)*DATA_W +: DATA_W]
valid_o  out  1  frame_o holds an unconsumed frame
ready_i  in  1  downstream accepts frame when valid_o && ready_i
overrun_o  out  1  sticky: a completed frame was dropped
frame_err_o  out  1  one-cycle pulse: slot length != SLOT_W
clear_i  in  1  synchronous clear of overrun_o

Behaviour:
- Reset: frame_o = 0, valid_o = 0, overrun_o = 0, frame_err_o = 0, FSM = S_SYNC, counters and shifters = 0. Reset mid-frame discards partial data; capture restarts at the next WS 1->0 transition.
- sck_rise = sck_i & ~sck_q (sck_q registered). On each sck_rise, ws_q <= ws_i; ws_chg = (ws_i != ws_q).
- Bit index k: k = 0 on an sck_rise with ws_chg; otherwise k increments, saturating at SLOT_W.
- Bits with DELAY_BITS <= k < DELAY_BITS + DATA_W shift into per-lane shifters, MSB first. All other bits are ignored.
- Slot check: on ws_chg, if the previous slot had been timed and k + 1 != SLOT_W, pulse frame_err_o, drop the staged left words, and go to S_SYNC. The first slot after S_SYNC is not checked.
- FSM:
  - S_SYNC -> S_LEFT on ws_chg with ws_i = 0.
  - S_LEFT: when the last data bit is shifted, copy the shifters to the left staging registers; -> S_RIGHT on ws_chg with ws_i = 1.
  - S_RIGHT: when the last data bit is shifted, the frame is complete; -> S_LEFT on ws_chg with ws_i = 0.
  - A WS edge of the wrong polarity for the state, or a slot ending before its last data bit, counts as a framing error and returns to S_SYNC.
- Commit: frame_o and valid_o update 2 clk_i cycles after the cycle in which sck_rise samples the final right-channel data bit.
- If valid_o && !ready_i at commit, the new frame is dropped, frame_o is unchanged, and overrun_o is set. If ready_i is high in the commit cycle, the old frame is consumed and the new one is loaded with valid_o staying 1.
- valid_o clears the cycle after a handshake if no commit occurs in that cycle. frame_o is stable while valid_o = 1.
- clear_i clears overrun_o. A simultaneous overrun event wins, so overrun_o stays 1.
- Right-slot length errors are detected at the following WS edge, after that frame was already delivered; only frame_err_o reports them.
- Elaboration assertions: DELAY_BITS + DATA_W <= SLOT_W, NUM_LANES >= 1.

Decomposition:
- Package i2s_rx_pkg:
  - State enum rx_state_e {S_SYNC, S_LEFT, S_RIGHT}.
  - Default width constants I2S_DATA_W = 24, I2S_SLOT_W = 32.
  - Function to compute the counter width, $clog2(SLOT_W+1).
- Sub-module i2s_lane_shifter(DATA_W): one DATA_W-bit MSB-first shift register with shift enable and synchronous clear, instantiated NUM_LANES times via generate. The FSM, counter and output register stay in the top module.

Test Plan:
- NUM_LANES = 2, I²S mode; lane0 L = 0x123456, R = 0xABCDEF; lane1 L = 0x800000, R = 0x7FFFFF; ready_i = 1 -> one valid_o pulse; frame_o = {0x7FFFFF, 0x800000, 0xABCDEF, 0x123456}, asserted exactly 2 clk after the last right bit.
- DELAY_BITS = 0 with the same words driven left-justified -> identical frame_o; with DELAY_BITS = 1 the same stream yields the words shifted left by 1 bit.
- Hold ready_i = 0 for 3 frames -> first frame held unchanged, overrun_o = 1; clear_i pulse -> overrun_o = 0; ready_i = 1 -> handshake, valid_o drops.
- Shorten one left slot to 30 SCK -> frame_err_o single pulse, no frame delivered for that frame, next complete frame delivered correctly.
- Assert rst_ni low mid-right-slot -> outputs 0 immediately; after release, first frame captured only after a WS 1->0 edge, starting in mid-stream.
- Start the stream in a right slot after reset -> no partial frame delivered; first valid_o carries a complete L+R pair.
